// File: rtl/uart_pkg.sv
// Shared constants and FSM encodings for the UART responder and its RX deserialiser.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 96;
  localparam int FRAME_BITS       = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;
endpackage

// File: rtl/uart_responder_rx.sv
// 8N1 receive path: 2-FF synchroniser, start/data/stop FSM and shift register.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

  logic          rxd_meta, rxd_sync, rxd_prev;
  uart_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          stop_ok, stop_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      rxd_meta  <= rxd;
      rxd_sync  <= rxd_meta;
      rxd_prev  <= rxd_sync;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      frame_err <= stop_bad;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    shift_n  = shift;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rxd_prev && !rxd_sync) state_n = START;
      end
      START: begin
        // Mid-bit check rejects glitches shorter than half a bit.
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxd_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          shift_n = {rxd_sync, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_MAX) begin
          cnt_n    = '0;
          state_n  = IDLE;
          stop_ok  = rxd_sync;
          stop_bad = !rxd_sync;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_valid = stop_ok;
  assign rx_byte    = shift;
endmodule

// File: rtl/uart_responder.sv
// UART peripheral behind a CPLD-style rdn/wrn strobe bus with one-byte RX and TX holding registers.
module uart_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] data_io,
  input  logic       rdn,
  input  logic       wrn,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd,
  output logic       overrun,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_param_chk
    $error("CLKS_PER_BIT must be at least 4");
  end

  logic       rdn_q, wrn_q;
  logic       rd_rise, commit;
  logic [7:0] wr_cap, tx_hold, rx_hold;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_load;

  uart_state_t   tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n, tx_idx_inc;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          txd_n, tsre_n;

  assign data_io = !rdn ? rx_hold : 8'hzz;

  assign rd_rise = rdn && !rdn_q;
  // Only a strobe whose last low cycle was a real capture (rdn high) commits.
  assign commit  = wrn && !wrn_q && rdn_q;

  uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .byte_valid(rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      wr_cap     <= '0;
      tx_hold    <= '0;
      tbre       <= 1'b1;
      rx_hold    <= '0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rdn_q <= rdn;
      wrn_q <= wrn;
      if (!wrn && rdn) wr_cap <= data_io;
      if (tx_load) tbre <= 1'b1;
      else if (commit && tbre) begin
        tx_hold <= wr_cap;
        tbre    <= 1'b0;
      end
      // A deposit landing on the read-clear edge wins over the clear.
      if (rx_valid && (!data_ready || rd_rise)) begin
        rx_hold    <= rx_byte;
        data_ready <= 1'b1;
      end else if (rd_rise) begin
        data_ready <= 1'b0;
      end
      if (rx_valid && data_ready && !rd_rise) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      tsre     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
      tsre     <= tsre_n;
    end
  end

  assign tx_idx_inc = tx_idx + 3'd1;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    tsre_n     = tsre;
    tx_load    = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        if (!tbre) begin
          tx_load    = 1'b1;
          tx_shift_n = tx_hold;
          txd_n      = 1'b0;
          tsre_n     = 1'b0;
          tx_state_n = START;
        end
      end
      START: begin
        if (tx_cnt == CNT_MAX) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          txd_n      = tx_shift[0];
          tx_state_n = DATA;
        end
      end
      DATA: begin
        if (tx_cnt == CNT_MAX) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = STOP;
          end else begin
            tx_idx_n = tx_idx_inc;
            txd_n    = tx_shift[tx_idx_inc];
          end
        end
      end
      STOP: begin
        if (tx_cnt == CNT_MAX) begin
          tx_cnt_n = '0;
          // Pending byte goes straight into a new start bit, no idle gap.
          if (!tbre) begin
            tx_load    = 1'b1;
            tx_shift_n = tx_hold;
            txd_n      = 1'b0;
            tx_state_n = START;
          end else begin
            tsre_n     = 1'b1;
            tx_state_n = IDLE;
          end
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end
endmodule
